// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher framer.
package cipher_pkg;

    localparam int unsigned DIR_W      = 2;
    localparam int unsigned SHIFT_W    = 5;
    localparam logic        HDR_MARKER = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload,
        StChksum
    } state_e;

endpackage

// File: rtl/cipher_framer_if.sv
// Upstream ciphertext, cipher config and downstream framed-beat signals.
interface cipher_framer_if #(
    parameter int unsigned N = 8
);
    import cipher_pkg::*;

    logic               in_v;
    logic [N-1:0]       in_data;
    logic [DIR_W-1:0]   direction;
    logic [SHIFT_W-1:0] shift_num;
    logic               out_rdy;
    logic               out_v;
    logic [N-1:0]       out_data;
    logic               out_last;
    logic               overflow;
    logic               busy;

    modport master (
        output in_v, in_data, direction, shift_num, out_rdy,
        input  out_v, out_data, out_last, overflow, busy
    );

    modport slave (
        input  in_v, in_data, direction, shift_num, out_rdy,
        output out_v, out_data, out_last, overflow, busy
    );

endinterface

// File: rtl/cipher_fifo.sv
// Synchronous count-based FIFO; push while full succeeds only alongside a pop.
module cipher_fifo #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [N-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [N-1:0]  rdata_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, push_ok, pop_ok;

    // Pointer/count next-state; pointers wrap at DEPTH.
    always_comb begin
        full_o  = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        pop_ok  = pop_i && !empty;
        push_ok = push_i && (!full_o || pop_ok);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push_ok) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        if (pop_ok)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        rdata_o = mem_q[rptr_q];
        count_o = count_q;
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cipher_framer.sv
// Buffers ciphertext words and emits header / payload / XOR checksum frames.
module cipher_framer
    import cipher_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    cipher_framer_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(FRAME_LEN + 1);

    state_e             state_q, state_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [N-1:0]       acc_q, acc_d;
    logic               overflow_q, overflow_d;
    logic [N-1:0]       head;
    logic [CW-1:0]      count;
    logic               full, pop;

    cipher_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (bus.in_v),
        .wdata_i (bus.in_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .count_o (count)
    );

    // Frame FSM next-state and combinational beat outputs.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        shift_d      = shift_q;
        beat_d       = beat_q;
        acc_d        = acc_q;
        pop          = 1'b0;
        bus.out_v    = 1'b0;
        bus.out_data = '0;
        bus.out_last = 1'b0;
        case (state_q)
            StIdle: begin
                if (count >= CW'(FRAME_LEN)) begin
                    dir_d   = bus.direction;
                    shift_d = bus.shift_num;
                    state_d = StHeader;
                end
            end
            StHeader: begin
                bus.out_v                             = 1'b1;
                bus.out_data[SHIFT_W-1:0]             = shift_q;
                bus.out_data[SHIFT_W +: DIR_W]        = dir_q;
                bus.out_data[DIR_W + SHIFT_W]         = HDR_MARKER;
                if (bus.out_rdy) begin
                    state_d = StPayload;
                    beat_d  = '0;
                    acc_d   = '0;
                end
            end
            StPayload: begin
                bus.out_v    = 1'b1;
                bus.out_data = head;
                if (bus.out_rdy) begin
                    pop    = 1'b1;
                    acc_d  = acc_q ^ head;
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(FRAME_LEN - 1)) state_d = StChksum;
                end
            end
            StChksum: begin
                bus.out_v    = 1'b1;
                bus.out_data = acc_q;
                bus.out_last = 1'b1;
                if (bus.out_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A write into a full FIFO is lost unless a pop frees a slot this cycle.
        overflow_d   = overflow_q | (bus.in_v & full & ~pop);
        bus.overflow = overflow_q;
        bus.busy     = (state_q != StIdle);
    end

    // Framer state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            dir_q      <= '0;
            shift_q    <= '0;
            beat_q     <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            shift_q    <= shift_d;
            beat_q     <= beat_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_cipher_framer.sv
// Scoreboard bench for cipher_framer: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_cipher_framer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [8:0] exp_q [$];

    cipher_framer_if #(.N(8)) bus ();

    cipher_framer #(
        .N         (8),
        .DEPTH     (8),
        .FRAME_LEN (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3,
                              input logic [7:0] chk);
        exp_q.push_back({1'b0, hdr});
        exp_q.push_back({1'b0, w0});
        exp_q.push_back({1'b0, w1});
        exp_q.push_back({1'b0, w2});
        exp_q.push_back({1'b0, w3});
        exp_q.push_back({1'b1, chk});
    endtask

    task automatic write_word(input logic [7:0] d);
        bus.in_v    = 1'b1;
        bus.in_data = d;
        @(posedge clk);
        #1;
        bus.in_v    = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        bus.in_v    = 1'b1;   // must be ignored while in reset
        bus.in_data = 8'h5A;
        bus.out_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.in_v = 1'b0;
        rst      = 1'b1;
        check("reset_out_v", 32'(bus.out_v), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);
        check("reset_out_last", 32'(bus.out_last), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
    endtask

    // Wait until every expected beat is seen and the framer is idle.
    task automatic wait_drain(input bit toggle, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (exp_q.size() == 0 && !bus.busy) begin
                done = 1'b1;
            end else begin
                bus.out_rdy = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
                @(posedge clk);
                #1;
            end
        end
        bus.out_rdy = 1'b1;
        check(name, 32'(done), 32'd1);
    endtask

    // Monitor: scoreboard compare, stall stability, idle gap, out_last/busy rules.
    logic       stall_q;
    logic       after_last_q;
    logic [8:0] prev_q;
    initial begin
        stall_q      = 1'b0;
        after_last_q = 1'b0;
        prev_q       = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                stall_q      = 1'b0;
                after_last_q = 1'b0;
            end else begin
                if (after_last_q) check("idle_gap_out_v", 32'(bus.out_v), 32'd0);
                if (stall_q) check("stall_stable", {22'd0, bus.out_v, bus.out_last, bus.out_data},
                                   {22'd0, 1'b1, prev_q});
                if (!bus.out_v) check("out_last_when_invalid", 32'(bus.out_last), 32'd0);
                else            check("busy_when_valid", 32'(bus.busy), 32'd1);
                if (bus.out_v && bus.out_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h expected none at %0t",
                                 {bus.out_last, bus.out_data}, $time);
                    end else begin
                        check("beat", 32'({bus.out_last, bus.out_data}), 32'(exp_q.pop_front()));
                    end
                end
                stall_q      = bus.out_v && !bus.out_rdy;
                after_last_q = bus.out_v && bus.out_rdy && bus.out_last;
                prev_q       = {bus.out_last, bus.out_data};
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.in_v      = 1'b0;
        bus.in_data   = '0;
        bus.direction = 2'd1;
        bus.shift_num = 5'd3;
        bus.out_rdy   = 1'b1;
        do_reset();

        // Basic frame: header 0x80|1<<5|3, checksum 0x11^0x22^0x44^0x88.
        push_frame(8'hA3, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF);
        write_word(8'h11); write_word(8'h22); write_word(8'h44); write_word(8'h88);
        wait_drain(1'b0, "drain_basic");

        // Same frame under 1,0,0,1 backpressure.
        push_frame(8'hA3, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF);
        write_word(8'h11); write_word(8'h22); write_word(8'h44); write_word(8'h88);
        wait_drain(1'b1, "drain_stall");

        // Overflow: 9 writes while stalled; ninth dropped. dir=2 shift=5 -> 0xC5.
        bus.direction = 2'd2;
        bus.shift_num = 5'd5;
        bus.out_rdy   = 1'b0;
        push_frame(8'hC5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        push_frame(8'hC5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0C);
        for (int i = 1; i <= 8; i++) write_word(8'(i));
        check("overflow_after_8", 32'(bus.overflow), 32'd0);
        write_word(8'h09);
        check("overflow_after_9", 32'(bus.overflow), 32'd1);
        wait_drain(1'b0, "drain_overflow");
        check("overflow_sticky", 32'(bus.overflow), 32'd1);
        do_reset();

        // Write into a full FIFO on the same cycle as a payload pop.
        bus.direction = 2'd0;
        bus.shift_num = 5'd31;
        bus.out_rdy   = 1'b0;
        push_frame(8'h9F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00);
        push_frame(8'h9F, 8'h14, 8'h15, 8'h16, 8'h17, 8'h00);
        for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
        check("full_overflow_clear", 32'(bus.overflow), 32'd0);
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        write_word(8'hAB);
        check("pop_push_overflow", 32'(bus.overflow), 32'd0);
        wait_drain(1'b0, "drain_full_a");
        push_frame(8'h9F, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h88);
        write_word(8'hCD); write_word(8'hEF); write_word(8'h01);
        wait_drain(1'b0, "drain_full_b");
        check("pop_push_overflow_end", 32'(bus.overflow), 32'd0);

        // Reset after the second payload beat aborts the frame and empties the FIFO.
        bus.direction = 2'd1;
        bus.shift_num = 5'd3;
        exp_q.push_back({1'b0, 8'hA3});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        write_word(8'h11); write_word(8'h22); write_word(8'h44); write_word(8'h88);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                if (exp_q.size() == 0) seen = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            check("abort_reached", 32'(seen), 32'd1);
        end
        rst         = 1'b0;
        bus.out_rdy = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out_v", 32'(bus.out_v), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out_last", 32'(bus.out_last), 32'd0);
        rst         = 1'b1;
        bus.out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'(bus.busy), 32'd0);
        bus.direction = 2'd3;
        bus.shift_num = 5'd1;
        push_frame(8'hE1, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F);
        write_word(8'h01); write_word(8'h02); write_word(8'h04); write_word(8'h08);
        wait_drain(1'b0, "drain_after_abort");

        // Eight zero words -> two zero-checksum frames with an idle gap.
        bus.direction = 2'd0;
        bus.shift_num = 5'd0;
        push_frame(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        push_frame(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) write_word(8'h00);
        wait_drain(1'b0, "drain_zeros");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
